// File: rtl/xf100_ifetch_resp.sv
// xf100_ifetch_resp: instruction fetch responder over a 1-cycle SRAM.
// One in-flight slot feeds a 2-entry in-order response FIFO under a 2-credit limit.
module xf100_ifetch_resp #(
    parameter int XF100_PC_SIZE = 32,
    parameter int XF100_INSTR_SIZE = 32,
    parameter int MEM_AW = 12,
    parameter logic [XF100_PC_SIZE-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ifu_req_valid,
    input  logic [XF100_PC_SIZE-1:0]    ifu_req_pc,
    output logic                        ifu_req_ready,
    output logic                        ifu_rsp_valid,
    output logic [XF100_INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                        ifu_rsp_err,
    input  logic                        ifu_rsp_ready,
    input  logic                        ifu_flush,
    output logic                        mem_cs,
    output logic [MEM_AW-1:0]           mem_addr,
    input  logic [XF100_INSTR_SIZE-1:0] mem_rdata
);
    logic                        r_slot_v;
    logic                        r_slot_err;
    logic [1:0]                  r_cnt;
    logic                        r_wp;
    logic                        r_rp;
    logic [XF100_INSTR_SIZE-1:0] r_data [2];
    logic [1:0]                  r_err;
    logic                        w_err;
    logic                        w_accept;
    logic                        w_push;
    logic                        w_pop;
    logic [1:0]                  w_committed;

    assign w_err = (ifu_req_pc[1:0] != 2'b00) ||
                   (ifu_req_pc[XF100_PC_SIZE-1:MEM_AW+2] != BASE_ADDR[XF100_PC_SIZE-1:MEM_AW+2]);
    assign ifu_rsp_valid = !rst && (r_cnt != 2'd0);
    assign w_pop = ifu_rsp_valid && ifu_rsp_ready;
    assign w_committed = r_cnt + {1'b0, r_slot_v};
    // a pop frees a credit in the same cycle, so a full pipe still streams
    assign ifu_req_ready = !rst && !ifu_flush && ((w_committed < 2'd2) || w_pop);
    assign w_accept = ifu_req_valid && ifu_req_ready;
    assign mem_cs = w_accept && !w_err;
    assign mem_addr = ifu_req_pc[MEM_AW+1:2];
    assign w_push = r_slot_v && !ifu_flush;
    assign ifu_rsp_instr = ifu_rsp_valid ? r_data[r_rp] : '0;
    assign ifu_rsp_err = ifu_rsp_valid && r_err[r_rp];

    always_ff @(posedge clk) begin
        if (rst || ifu_flush) begin
            r_slot_v   <= 1'b0;
            r_slot_err <= 1'b0;
            r_cnt      <= 2'd0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
        end else begin
            r_slot_v   <= w_accept;
            r_slot_err <= w_err;
            r_cnt      <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) r_wp <= ~r_wp;
            if (w_pop) r_rp <= ~r_rp;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_data[r_wp] <= r_slot_err ? '0 : mem_rdata;
            r_err[r_wp]  <= r_slot_err;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(w_push && !w_pop && r_cnt == 2'd2));
endmodule

// File: tb/tb_xf100_ifetch_resp.sv
// tb_xf100_ifetch_resp: directed fetch scenarios with a scoreboard queue of expected responses.
module tb_xf100_ifetch_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic [31:0] ifu_req_pc = 32'h0;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic        ifu_rsp_ready = 1'b0;
    logic        ifu_flush = 1'b0;
    logic        mem_cs;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    int          errs = 0;
    int          checks = 0;
    int          n;
    logic [32:0] q[$];

    xf100_ifetch_resp dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_pc(ifu_req_pc), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
        .ifu_rsp_ready(ifu_rsp_ready), .ifu_flush(ifu_flush),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [11:0] a);
        return (a == 12'h004) ? 32'h0000_0013 : {8'hC3, a, ~a};
    endfunction

    function automatic logic [32:0] expect_of(input logic [31:0] pc);
        logic e;
        e = (pc[1:0] != 2'b00) || (pc[31:14] != 18'h20000);
        return e ? {1'b1, 32'h0} : {1'b0, instr_of(pc[13:2])};
    endfunction

    // garbage when idle so an error response that leaks SRAM data is caught
    always @(posedge clk) mem_rdata <= mem_cs ? instr_of(mem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        if (!ifu_rsp_valid) chk("idle_instr_zero", {1'b0, ifu_rsp_instr}, 33'h0);
        if (ifu_rsp_valid && ifu_rsp_ready) begin
            chk("rsp_expected", {32'h0, q.size() != 0}, 33'h1);
            if (q.size() != 0) chk("rsp_data", {ifu_rsp_err, ifu_rsp_instr}, q.pop_front());
        end
        if (ifu_req_valid && ifu_req_ready) q.push_back(expect_of(ifu_req_pc));
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_ready", ifu_req_ready, 0);
            chk("rst_valid", ifu_rsp_valid, 0);
            chk("rst_err", ifu_rsp_err, 0);
            chk("rst_cs", mem_cs, 0);
            cyc();
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ifu_req_ready, 1);
        cyc();

        // single fetch, 2-cycle latency
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0010; ifu_rsp_ready = 1'b1;
        #1;
        chk("single_cs", mem_cs, 1);
        chk("single_addr", {21'h0, mem_addr}, 33'h004);
        chk("single_valid_c0", ifu_rsp_valid, 0);
        cyc();
        ifu_req_valid = 1'b0;
        #1;
        chk("single_valid_c1", ifu_rsp_valid, 0);
        cyc();
        #1;
        chk("single_valid_c2", ifu_rsp_valid, 1);
        chk("single_rsp", {ifu_rsp_err, ifu_rsp_instr}, {1'b0, 32'h0000_0013});
        cyc();
        #1;
        cyc();

        // streaming at one fetch per cycle
        for (int k = 0; k < 12; k++) begin
            ifu_req_valid = (k < 8);
            ifu_req_pc = 32'h8000_0000 + 32'(4 * k);
            #1;
            if (k < 8) chk("stream_ready", ifu_req_ready, 1);
            chk("stream_valid", ifu_rsp_valid, (k >= 2 && k <= 9));
            cyc();
        end
        ifu_req_valid = 1'b0;
        chk("stream_drained", 33'(q.size()), 33'd0);

        // backpressure: only two credits
        ifu_rsp_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            ifu_rsp_ready = (k >= 4);
            ifu_req_valid = (n < 4);
            ifu_req_pc = 32'h8000_0100 + 32'(4 * n);
            #1;
            chk("bp_ready", ifu_req_ready, (k < 2 || k >= 4));
            if (k == 2 || k == 3) chk("bp_hold", {ifu_rsp_err, ifu_rsp_instr}, q[0]);
            if (ifu_req_ready) n++;
            cyc();
        end
        ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin #1; cyc(); end
        chk("bp_drained", 33'(q.size()), 33'd0);

        // faults then a good fetch
        for (int k = 0; k < 3; k++) begin
            ifu_req_valid = 1'b1;
            ifu_req_pc = (k == 0) ? 32'h8000_0002 : (k == 1) ? 32'h9000_0000 : 32'h8000_0020;
            #1;
            chk("fault_cs", mem_cs, (k == 2));
            cyc();
        end
        ifu_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin #1; cyc(); end
        chk("fault_drained", 33'(q.size()), 33'd0);

        // flush with FIFO and slot both occupied
        ifu_rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0200 + 32'(4 * k);
            #1;
            cyc();
        end
        ifu_flush = 1'b1; ifu_req_pc = 32'h8000_0300;
        #1;
        chk("flush_ready", ifu_req_ready, 0);
        chk("flush_cs", mem_cs, 0);
        chk("flush_valid_f", ifu_rsp_valid, 1);
        cyc();
        q.delete();
        ifu_flush = 1'b0; ifu_rsp_ready = 1'b1; ifu_req_pc = 32'h8000_0304;
        #1;
        chk("flush_valid_f1", ifu_rsp_valid, 0);
        chk("flush_ready_f1", ifu_req_ready, 1);
        cyc();
        ifu_req_valid = 1'b0;
        #1;
        chk("flush_valid_f2", ifu_rsp_valid, 0);
        cyc();
        #1;
        chk("flush_valid_f3", ifu_rsp_valid, 1);
        chk("flush_rsp_f3", {ifu_rsp_err, ifu_rsp_instr}, expect_of(32'h8000_0304));
        cyc();
        for (int k = 0; k < 3; k++) begin #1; cyc(); end

        // reset mid-stream with two responses pending
        ifu_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifu_req_valid = (k < 2); ifu_req_pc = 32'h8000_0400 + 32'(4 * k);
            #1;
            cyc();
        end
        rst = 1'b1;
        #1;
        chk("mrst_ready", ifu_req_ready, 0);
        chk("mrst_cs", mem_cs, 0);
        cyc();
        q.delete();
        rst = 1'b0; ifu_rsp_ready = 1'b1;
        #1;
        chk("mrst_valid", ifu_rsp_valid, 0);
        chk("mrst_err", ifu_rsp_err, 0);
        chk("mrst_instr", {1'b0, ifu_rsp_instr}, 33'h0);
        chk("mrst_cs_after", mem_cs, 0);
        chk("mrst_ready_after", ifu_req_ready, 1);
        cyc();
        for (int k = 0; k < 4; k++) begin #1; cyc(); end
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0044;
        #1;
        cyc();
        ifu_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin #1; cyc(); end
        chk("final_drained", 33'(q.size()), 33'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/xf100_ifetch_resp.md
XF100_IFETCH_RESP -- requirements
Module: xf100_ifetch_resp

Interface
REQ-001 Parameter: XF100_PC_SIZE, default 32, width of the fetch PC.
REQ-002 Parameter: XF100_INSTR_SIZE, default 32, width of the instruction word.
REQ-003 Parameter: MEM_AW, default 12, SRAM word-address width (4096 words, 16 KB).
REQ-004 Parameter: BASE_ADDR, default 32'h8000_0000, byte base address of the instruction region; aligned to 2^(MEM_AW+2).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ifu_req_valid  input  1  fetch request valid.
REQ-008 ifu_req_pc  input  XF100_PC_SIZE  fetch byte address.
REQ-009 ifu_req_ready  output  1  responder can accept a request.
REQ-010 ifu_rsp_valid  output  1  response valid.
REQ-011 ifu_rsp_instr  output  XF100_INSTR_SIZE  fetched instruction.
REQ-012 ifu_rsp_err  output  1  fetch fault (misaligned or out of range).
REQ-013 ifu_rsp_ready  input  1  IFU accepts the response.
REQ-014 ifu_flush  input  1  discard all buffered and in-flight fetches.
REQ-015 mem_cs  output  1  SRAM read enable.
REQ-016 mem_addr  output  MEM_AW  SRAM word address.
REQ-017 mem_rdata  input  XF100_INSTR_SIZE  SRAM read data, valid one cycle after mem_cs.

Function
REQ-018 Accept: a request is accepted in a cycle with ifu_req_valid && ifu_req_ready.
REQ-019 Error check at accept: misaligned if pc[1:0] != 0; out of range if pc[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]; either sets the error flag.
REQ-020 mem_cs is driven combinationally: mem_cs = accept && !error; mem_addr = pc[MEM_AW+1:2]; otherwise mem_cs = 0.
REQ-021 Stage 1 register: one in-flight slot {valid, err}, loaded on accept, cleared otherwise.
REQ-022 In the cycle after accept, the slot writes {mem_rdata, 0} into a 2-entry response FIFO; for err it writes {0, 1} instead.
REQ-023 Latency: accept in cycle N gives ifu_rsp_valid in cycle N+2 at the earliest; responses are returned strictly in request order.
REQ-024 ifu_rsp_valid/ifu_rsp_instr/ifu_rsp_err come from the FIFO head register; a pop occurs on ifu_rsp_valid && ifu_rsp_ready.
REQ-025 Output stability: while ifu_rsp_valid=1 and ifu_rsp_ready=0, ifu_rsp_instr and ifu_rsp_err hold their values.
REQ-026 Credit: committed = fifo_count + slot_valid.
REQ-027 ifu_req_ready = !ifu_flush && (committed < 2 || pop), i.e. a combinational path from ifu_rsp_ready; this sustains 1 fetch per cycle.
REQ-028 Simultaneous push and pop keeps the count unchanged.
REQ-029 Simultaneous push and pop on an empty FIFO is impossible, because the head is registered and there is no bypass.
REQ-030 FIFO wrap-around: write and read pointers are 1 bit and toggle independently; fifo_count lies in 0..2.
REQ-031 The FIFO never overflows; a push while fifo_count=2 without a pop is a design error and is flagged by an assertion.
REQ-032 Flush in cycle F:
 - sets fifo_count to 0 and clears slot_valid at the end of F;
 - drops the slot's mem_rdata;
 - forces ifu_req_ready=0 and mem_cs=0 during F;
 - ifu_rsp_valid is 0 from F+1.
REQ-033 Flush has priority over push, pop and accept in the same cycle.
REQ-034 A pop during F still counts as a handshake for the IFU; the IFU owns discarding it.
REQ-035 ifu_rsp_instr is 0 when ifu_rsp_valid=0.

Reset
REQ-036 While rst=1, at each clock edge: fifo_count=0, pointers=0, slot_valid=0.
REQ-037 Outputs during and after reset: ifu_rsp_valid=0, ifu_rsp_err=0, ifu_rsp_instr=0, mem_cs=0.
REQ-038 ifu_req_ready is 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-039 Reset mid-operation discards every outstanding fetch, and no response is produced for them.

Verification
REQ-040 Single fetch: pc=0x8000_0010 accepted in cycle 0 -> mem_cs=1 and mem_addr=0x004 in cycle 0; mem_rdata=0x0000_0013 in cycle 1; rsp_valid=1, instr=0x0000_0013, err=0 in cycle 2.
REQ-041 Streaming: req_valid held for 8 cycles on pc 0x8000_0000..0x8000_001C with rsp_ready=1 -> req_ready stays 1 and 8 in-order responses come out on consecutive cycles 2..9.
REQ-042 Backpressure: rsp_ready=0 while 4 requests are offered -> exactly 2 are accepted and req_ready=0 from cycle 2; raising rsp_ready drains the 2 responses in order, then acceptance resumes.
REQ-043 Faults: pc=0x8000_0002 -> err=1, instr=0, no mem_cs; pc=0x9000_0000 -> err=1; a valid fetch that follows returns err=0 in order.
REQ-044 Flush: FIFO holds 2 responses and the slot is full; ifu_flush pulses in cycle F -> rsp_valid=0 from F+1, req_ready=0 in F; a new fetch accepted at F+1 responds at F+3.
REQ-045 Reset mid-stream: rst=1 for 1 cycle while 2 responses are pending -> every output matches REQ-037 on the next cycle and no stale response ever appears.
